// File: rtl/irq_aggregator.sv
// irq_aggregator: gathers up to 16 IRQ lines, masks them and drives one CPU interrupt,
// with a 16-bit Avalon-MM slave. Define IRQ_AGGREGATOR_EDGE_EN to build edge-triggered sources.
module irq_aggregator #(
    parameter int unsigned NUM_IRQ    = 8,
    parameter logic [15:0] RESET_MASK = 16'h0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    output logic               irq
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned IDX_W  = 4;

    localparam logic [2:0] ADDR_PENDING = 3'd0;
    localparam logic [2:0] ADDR_MASK    = 3'd1;
    localparam logic [2:0] ADDR_EDGE    = 3'd2;
    localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
    localparam logic [2:0] ADDR_RAW     = 3'd4;

    logic [NUM_IRQ-1:0] irq_in_q, irq_in_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [DATA_W-1:0]  readdata_q, readdata_d;
    logic               irq_out_q, irq_out_d;

    logic               wr_en_c;
    logic [NUM_IRQ-1:0] wdata_c;
    logic [NUM_IRQ-1:0] masked_c;
    logic [IDX_W-1:0]   active_idx_c;
    logic               active_vld_c;
    logic [DATA_W-1:0]  edge_rd_c;
    logic [DATA_W-1:0]  rd_mux_c;

    // Upper write-data bits are dropped when fewer than 16 sources are built.
    logic               unused_wdata;
    assign unused_wdata = ^writedata;

    assign readdata = readdata_q;
    assign irq      = irq_out_q;

`ifdef IRQ_AGGREGATOR_EDGE_EN
    logic [NUM_IRQ-1:0] irq_in_dly_q, irq_in_dly_d;
    logic [NUM_IRQ-1:0] edge_q, edge_d;
    logic [NUM_IRQ-1:0] rise_c;
    logic [NUM_IRQ-1:0] w1c_c;
    logic [NUM_IRQ-1:0] mode_chg_c;
`endif

    // Bus decode and register next-state.
    always_comb begin
        wr_en_c  = chipselect & ~write_n;
        wdata_c  = writedata[NUM_IRQ-1:0];
        irq_in_d = irq_in;

        mask_d = mask_q;
        if (wr_en_c && (address == ADDR_MASK)) begin
            mask_d = wdata_c;
        end

`ifdef IRQ_AGGREGATOR_EDGE_EN
        irq_in_dly_d = irq_in_q;
        edge_d       = edge_q;
        if (wr_en_c && (address == ADDR_EDGE)) begin
            edge_d = wdata_c;
        end
        mode_chg_c = edge_d ^ edge_q;
        w1c_c      = (wr_en_c && (address == ADDR_PENDING)) ? wdata_c : '0;
        rise_c     = irq_in_q & ~irq_in_dly_q;

        // Edge latches: a rising edge outranks a W1C clear; a mode switch flushes the bit.
        pending_d = (edge_q & ((pending_q & ~w1c_c) | rise_c))
                  | (~edge_q & irq_in_q);
        pending_d = pending_d & ~mode_chg_c;
        edge_rd_c = DATA_W'(edge_q);
`else
        pending_d = irq_in_q;
        edge_rd_c = '0;
`endif

        masked_c  = pending_q & mask_q;
        irq_out_d = |masked_c;
    end

    // Lowest-numbered enabled pending source.
    always_comb begin
        active_idx_c = '0;
        active_vld_c = 1'b0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (masked_c[i]) begin
                active_idx_c = IDX_W'(i);
                active_vld_c = 1'b1;
            end
        end
    end

    // Read mux sees pre-edge state, so a same-cycle write returns the old value.
    always_comb begin
        rd_mux_c = '0;
        case (address)
            ADDR_PENDING: rd_mux_c = DATA_W'(pending_q);
            ADDR_MASK:    rd_mux_c = DATA_W'(mask_q);
            ADDR_EDGE:    rd_mux_c = edge_rd_c;
            ADDR_ACTIVE:  rd_mux_c = {active_vld_c, 11'b0, active_idx_c};
            ADDR_RAW:     rd_mux_c = DATA_W'(irq_in_q);
            default:      rd_mux_c = '0;
        endcase
        readdata_d = chipselect ? rd_mux_c : readdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_in_q   <= '0;
            pending_q  <= '0;
            mask_q     <= RESET_MASK[NUM_IRQ-1:0];
            readdata_q <= '0;
            irq_out_q  <= 1'b0;
        end else begin
            irq_in_q   <= irq_in_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            readdata_q <= readdata_d;
            irq_out_q  <= irq_out_d;
        end
    end

`ifdef IRQ_AGGREGATOR_EDGE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_in_dly_q <= '0;
            edge_q       <= '0;
        end else begin
            irq_in_dly_q <= irq_in_dly_d;
            edge_q       <= edge_d;
        end
    end
`endif

endmodule
